wb_port_arbiter: RTL and testbench
==================================

// Module: wb_port_arbiter
// PURPOSE
//  Shares the single register-file write port between NUM_REQ writeback sources
//  (ALU, load unit, multi-cycle MUL/DIV, ...) using round-robin arbitration.
//  Sits between the execute/memory stages and the register file.
//  The winning write is captured into output flops and presented to the regfile
//  one cycle later. Losers are back-pressured via valid/ready.
// PARAMETERS
//  NUM_REQ  3   number of writeback requesters, legal 2..8
//  XLEN     32  data width of a register write
//  ADDR_W   5   register index width (x0..x31)
//  GNT_W    $clog2(NUM_REQ)  localparam, width of the grant index
// PORTS
//  clk          in   1               clock; all flops update on the rising edge
//  rst          in   1               asynchronous, active-high reset
//  req_valid    in   NUM_REQ         requester i has a write pending
//  req_rd       in   NUM_REQ*ADDR_W  dest index, slice i = [i*ADDR_W +: ADDR_W]
//  req_data     in   NUM_REQ*XLEN    write data, slice i = [i*XLEN +: XLEN]
//  req_ready    out  NUM_REQ         one-hot grant; transfer when valid&ready
//  rf_we        out  1               registered regfile write enable
//  rf_waddr     out  ADDR_W          registered regfile write index
//  rf_wdata     out  XLEN            registered regfile write data
//  gnt_id       out  GNT_W           registered index of the last accepted requester
// BEHAVIOUR
//  - Reset (async, immediate): rf_we=0, rf_waddr=0, rf_wdata=0, gnt_id=0, rr_ptr=0.
//    req_ready is 0 while rst=1. Nothing is accepted during reset.
//  - Arbitration is combinational each cycle:
//    - Scan req_valid starting at rr_ptr, wrapping modulo NUM_REQ.
//    - The first valid requester gets req_ready=1; all others get 0.
//    - No valid requester -> req_ready all 0.
//  - req_ready may depend on req_valid. A requester must hold valid/rd/data stable
//    until accepted, and must not drop valid before acceptance.
//  - Accept edge, when req_valid[g]&req_ready[g]:
//    - rf_waddr<=req_rd[g], rf_wdata<=req_data[g], gnt_id<=g, rr_ptr<=(g+1) mod NUM_REQ.
//    - rf_we<=1 if req_rd[g]!=0, else 0. A write to x0 is accepted (consumed)
//      but suppressed.
//  - Latency is exactly 1 cycle from accept to rf_we. Throughput is one write per cycle.
//    The regfile always accepts, so there is no output back-pressure.
//  - No accept in a cycle: rf_we<=0. rf_waddr, rf_wdata, gnt_id and rr_ptr hold.
//  - rr_ptr wrap: g=NUM_REQ-1 -> rr_ptr=0. rr_ptr never holds a value >= NUM_REQ.
//  - Fairness: a continuously valid requester is granted within NUM_REQ cycles.
//  - Reset mid-operation: pending requests are dropped by the arbiter (not accepted).
//    Requesters are reset by the same rst.
//  - Out-of-range requester bits are not generated. NUM_REQ must be >= 2;
//    this is checked with an elaboration-time error.
// CONFIGURATION
//  - WBARB_PRIO0_EN defined:
//    - Requester 0 (load unit) has fixed highest priority. If req_valid[0]=1 it
//      wins regardless of rr_ptr.
//    - rr_ptr is not updated on a requester-0 win.
//    - Requesters 1..NUM_REQ-1 round-robin among themselves as above. The rr_ptr
//      scan skips index 0, and wrap goes to 1.
//  - WBARB_PRIO0_EN undefined: pure round-robin over all NUM_REQ requesters.
// TESTING
//  1 rst=1 with all req_valid=1 -> req_ready=0, rf_we=0.
//    Release rst -> first accept is req 0, and rf_we=1 on the next cycle.
//  2 Only req 1 valid, rd=5, data=32'hDEAD_BEEF -> req_ready=3'b010.
//    Next cycle rf_we=1, rf_waddr=5, rf_wdata=32'hDEAD_BEEF, gnt_id=1.
//  3 All 3 valid for 6 cycles -> grants 0,1,2,0,1,2. rf_we is high on every cycle
//    after the first, with no bubbles.
//  4 Req 2 valid, rd=0, data=32'h1234 -> req_ready[2]=1 and the request is consumed.
//    Next cycle rf_we=0, and rr_ptr advances to 0.
//  5 Accept on req 1, then assert rst for 1 cycle mid-stream -> rf_we drops
//    immediately, rr_ptr=0, and the next grant goes to the lowest valid index.
//  6 WBARB_PRIO0_EN, reqs 0 and 2 valid continuously -> req 0 wins every cycle
//    and req 2 is starved.
//    Drop req 0 -> req 2 is granted on the next cycle.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter for the single register-file write port, with a registered write stage.
// Define WBARB_PRIO0_EN to give requester 0 fixed top priority over a round-robin of the others.
module wb_port_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 5,
    localparam int GNT_W  = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_rd,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_waddr,
    output logic [XLEN-1:0]           rf_wdata,
    output logic [GNT_W-1:0]          gnt_id
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("wb_port_arbiter: NUM_REQ must be in 2..8");
    end

    logic [GNT_W-1:0]  rr_ptr;
    logic [GNT_W-1:0]  rr_next;
    logic [GNT_W-1:0]  gnt;
    logic              found;
    logic [ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]   sel_data;

    // Pick the first valid requester, scanning upward from rr_ptr with wrap.
    always_comb begin
        int pos;
        logic [GNT_W-1:0] pos_idx;
        // NOTE: every signal gets a default before any branch, so no latch is inferred.
        found   = 1'b0;
        gnt     = '0;
        pos     = 0;
        pos_idx = '0;
`ifdef WBARB_PRIO0_EN
        if (req_valid[0]) begin
            found = 1'b1;
        end else begin
            // Index 0 is outside the rotation; a pointer of 0 starts the scan at 1.
            for (int k = 0; k < NUM_REQ - 1; k++) begin
                pos = ((rr_ptr == '0) ? 1 : int'(rr_ptr)) + k;
                if (pos >= NUM_REQ) pos = pos - (NUM_REQ - 1);
                pos_idx = GNT_W'(pos);
                if (!found && req_valid[pos_idx]) begin
                    found = 1'b1;
                    gnt   = pos_idx;
                end
            end
        end
`else
        for (int k = 0; k < NUM_REQ; k++) begin
            pos = int'(rr_ptr) + k;
            if (pos >= NUM_REQ) pos = pos - NUM_REQ;
            pos_idx = GNT_W'(pos);
            if (!found && req_valid[pos_idx]) begin
                found = 1'b1;
                gnt   = pos_idx;
            end
        end
`endif
    end

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (GNT_W'(i) == gnt) begin
                sel_rd   = req_rd[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    always_comb begin
        rr_next = rr_ptr;
`ifdef WBARB_PRIO0_EN
        if (gnt != '0) rr_next = (int'(gnt) == NUM_REQ - 1) ? GNT_W'(1) : gnt + GNT_W'(1);
`else
        rr_next = (int'(gnt) == NUM_REQ - 1) ? '0 : gnt + GNT_W'(1);
`endif
    end

    // Nothing is offered while reset is held, so no transfer can complete.
    always_comb begin
        req_ready = '0;
        if (found && !rst) req_ready[gnt] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            gnt_id   <= '0;
            rr_ptr   <= '0;
        end else if (found) begin
            rf_we    <= (sel_rd != '0);
            rf_waddr <= sel_rd;
            rf_wdata <= sel_data;
            gnt_id   <= gnt;
            rr_ptr   <= rr_next;
        end else begin
            rf_we <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (NUM_REQ=3): vector table plus reset sequences.
// Define WBARB_PRIO0_EN for both bench and RTL to exercise the fixed-priority build.
module tb_wb_port_arbiter;

    localparam int NUM_REQ = 3;
    localparam int XLEN    = 32;
    localparam int ADDR_W  = 5;
    localparam int GNT_W   = 2;

    logic                      clk;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_rd;
    logic [NUM_REQ*XLEN-1:0]   req_data;
    logic [NUM_REQ-1:0]        req_ready;
    logic                      rf_we;
    logic [ADDR_W-1:0]         rf_waddr;
    logic [XLEN-1:0]           rf_wdata;
    logic [GNT_W-1:0]          gnt_id;

    wb_port_arbiter #(.NUM_REQ(NUM_REQ), .XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .gnt_id    (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string                     name;
        logic [NUM_REQ-1:0]        valid;
        logic [NUM_REQ*ADDR_W-1:0] rd;
        logic [NUM_REQ*XLEN-1:0]   data;
        logic [NUM_REQ-1:0]        exp_ready;
        logic                      exp_we;
        logic [ADDR_W-1:0]         exp_waddr;
        logic [XLEN-1:0]           exp_wdata;
        logic [GNT_W-1:0]          exp_gnt;
    } vec_t;

    // Requester i normally writes rd=i+1 with a recognisable data word.
    localparam logic [NUM_REQ*ADDR_W-1:0] RD_STD   = {5'd3, 5'd2, 5'd1};
    localparam logic [NUM_REQ*XLEN-1:0]   DATA_STD = {32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
    localparam logic [XLEN-1:0] D0 = 32'hA0A0_0000;
    localparam logic [XLEN-1:0] D1 = 32'hB1B1_0001;
    localparam logic [XLEN-1:0] D2 = 32'hC2C2_0002;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic [2:0] valid,
                                input logic [14:0] rd, input logic [95:0] data,
                                input logic [2:0] exp_ready, input logic exp_we,
                                input logic [4:0] exp_waddr, input logic [31:0] exp_wdata,
                                input logic [1:0] exp_gnt);
        vec_t v;
        v.name = name; v.valid = valid; v.rd = rd; v.data = data;
        v.exp_ready = exp_ready; v.exp_we = exp_we; v.exp_waddr = exp_waddr;
        v.exp_wdata = exp_wdata; v.exp_gnt = exp_gnt;
        return v;
    endfunction

    initial begin
        // Round-robin state after the first accept (req 0): rr_ptr=1 (pure RR) or 0 (prio build).
`ifdef WBARB_PRIO0_EN
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk("prio_r0_starves_r2", 3'b101, RD_STD, DATA_STD, 3'b001, 1'b1, 5'd1, D0, 2'd0));
        vecs.push_back(mk("prio_r0_drop_r2", 3'b100, RD_STD, DATA_STD, 3'b100, 1'b1, 5'd3, D2, 2'd2));
        vecs.push_back(mk("prio_wrap_to_1", 3'b110, RD_STD, DATA_STD, 3'b010, 1'b1, 5'd2, D1, 2'd1));
        vecs.push_back(mk("prio_r0_beats_ptr", 3'b111, RD_STD, DATA_STD, 3'b001, 1'b1, 5'd1, D0, 2'd0));
        vecs.push_back(mk("prio_ptr_held", 3'b110, RD_STD, DATA_STD, 3'b100, 1'b1, 5'd3, D2, 2'd2));
        vecs.push_back(mk("prio_x0_write", 3'b100, {5'd0, 5'd2, 5'd1},
                          {32'h0000_1234, D1, D0}, 3'b100, 1'b0, 5'd0, 32'h0000_1234, 2'd2));
`else
        vecs.push_back(mk("only_r1", 3'b010, {5'd3, 5'd5, 5'd1},
                          {D2, 32'hDEAD_BEEF, D0}, 3'b010, 1'b1, 5'd5, 32'hDEAD_BEEF, 2'd1));
        vecs.push_back(mk("x0_write", 3'b100, {5'd0, 5'd2, 5'd1},
                          {32'h0000_1234, D1, D0}, 3'b100, 1'b0, 5'd0, 32'h0000_1234, 2'd2));
        vecs.push_back(mk("idle_hold", 3'b000, RD_STD, DATA_STD, 3'b000, 1'b0, 5'd0, 32'h0000_1234, 2'd2));
        for (int i = 0; i < 2; i++) begin
            vecs.push_back(mk("all_valid_g0", 3'b111, RD_STD, DATA_STD, 3'b001, 1'b1, 5'd1, D0, 2'd0));
            vecs.push_back(mk("all_valid_g1", 3'b111, RD_STD, DATA_STD, 3'b010, 1'b1, 5'd2, D1, 2'd1));
            vecs.push_back(mk("all_valid_g2", 3'b111, RD_STD, DATA_STD, 3'b100, 1'b1, 5'd3, D2, 2'd2));
        end
`endif

        // Reset held with every requester valid: nothing offered, outputs cleared.
        rst       = 1'b1;
        req_valid = 3'b111;
        req_rd    = RD_STD;
        req_data  = DATA_STD;
        #1;
        step();
        step();
        check("rst_ready", 32'(req_ready), 32'(3'b000));
        check("rst_we", 32'(rf_we), 32'd0);
        check("rst_waddr", 32'(rf_waddr), 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);
        check("rst_gnt", 32'(gnt_id), 32'd0);

        rst = 1'b0;
        #1;
        check("first_ready", 32'(req_ready), 32'(3'b001));
        step();
        check("first_we", 32'(rf_we), 32'd1);
        check("first_waddr", 32'(rf_waddr), 32'd1);
        check("first_wdata", rf_wdata, D0);
        check("first_gnt", 32'(gnt_id), 32'd0);

        foreach (vecs[i]) begin
            req_valid = vecs[i].valid;
            req_rd    = vecs[i].rd;
            req_data  = vecs[i].data;
            #1;
            check({vecs[i].name, "_ready"}, 32'(req_ready), 32'(vecs[i].exp_ready));
            step();
            check({vecs[i].name, "_we"}, 32'(rf_we), 32'(vecs[i].exp_we));
            check({vecs[i].name, "_waddr"}, 32'(rf_waddr), 32'(vecs[i].exp_waddr));
            check({vecs[i].name, "_wdata"}, rf_wdata, vecs[i].exp_wdata);
            check({vecs[i].name, "_gnt"}, 32'(gnt_id), 32'(vecs[i].exp_gnt));
        end

        // Accept on req 1 (rr_ptr -> 2), then reset mid-stream with reqs 1 and 2 pending.
        req_valid = 3'b010;
        req_rd    = RD_STD;
        req_data  = DATA_STD;
        #1;
        check("mid_r1_ready", 32'(req_ready), 32'(3'b010));
        step();
        check("mid_r1_we", 32'(rf_we), 32'd1);
        check("mid_r1_gnt", 32'(gnt_id), 32'd1);
        req_valid = 3'b110;
        #1;
        check("mid_no_rst_ready", 32'(req_ready), 32'(3'b100));
        rst = 1'b1;
        #1;
        check("mid_rst_we_async", 32'(rf_we), 32'd0);
        check("mid_rst_ready", 32'(req_ready), 32'(3'b000));
        check("mid_rst_gnt", 32'(gnt_id), 32'd0);
        step();
        check("mid_rst_edge_we", 32'(rf_we), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_ready", 32'(req_ready), 32'(3'b010));
        step();
        check("post_rst_we", 32'(rf_we), 32'd1);
        check("post_rst_waddr", 32'(rf_waddr), 32'd2);
        check("post_rst_gnt", 32'(gnt_id), 32'd1);

        req_valid = 3'b000;
        #1;
        check("end_idle_ready", 32'(req_ready), 32'(3'b000));
        step();
        check("end_idle_we", 32'(rf_we), 32'd0);
        check("end_idle_waddr_hold", 32'(rf_waddr), 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
